mac_ctrl_encoder_16_vert_2: RTL and testbench
=============================================

MAC_CTRL_ENCODER_16_VERT_2 -- requirements
Module: mac_ctrl_encoder_16_vert_2

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, weight bit width (= number of bit columns); VEC_LENGTH, default 16, weights per vector (2 groups of 8); MUX_SEL_WIDTH, default $clog2(VEC_LENGTH)+1, hamming select width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 w_valid  in  1  weight vector offered.
REQ-005 w_ready  out  1  encoder can accept a weight vector.
REQ-006 weight  in  DATA_WIDTH x VEC_LENGTH  signed two's-complement weights; lane i belongs to group i/8.
REQ-007 stall  in  1  downstream hold; freezes the current column.
REQ-008 en  out  1  current column outputs are valid; drives the MAC accumulate enable.
REQ-009 act_sel  out  (MUX_SEL_WIDTH-1) x VEC_LENGTH/2  per-slot activation select; slots 4g..4g+3 serve group g; value 0..7 = lane within group, 8 = zero input.
REQ-010 is_skip_zero  out  1 x 2  per group: 1 = selected lanes are the 1-bits, 0 = selected lanes are the 0-bits.
REQ-011 column_idx  out  3  bit column index (shift amount).
REQ-012 is_msb  out  1  current column is the sign column.
REQ-013 first_col / last_col  out  1 each  column 0 / column DATA_WIDTH-1 marker.
REQ-014 hamming_sel  out  MUX_SEL_WIDTH;  hamming_sign, is_shift_mul  out  1;  mul_const  out  3  special-PE controls.
REQ-015 busy  out  1  a vector is being emitted.

Function
REQ-016 The FSM SHALL have states IDLE and EMIT; IDLE -> EMIT on w_valid && w_ready; EMIT -> IDLE after column DATA_WIDTH-1 is presented with stall=0.
REQ-017 w_ready SHALL equal (state == IDLE); the accepted vector SHALL be captured into an internal register on the handshake cycle.
REQ-018 Column 0 SHALL be presented (en=1) on the cycle after the handshake; one column per unstalled cycle, ascending 0..DATA_WIDTH-1.
REQ-019 While stall=1 in EMIT, every output SHALL hold its value and the column counter SHALL not advance; en SHALL remain 1.
REQ-020 For column c, group g: k = popcount of bit c over lanes 8g..8g+7.
REQ-021 If k <= 4: is_skip_zero[g]=1 and slots 4g.. are filled with lane indices (0..7) whose bit c = 1.
REQ-022 If k >= 5: is_skip_zero[g]=0 and slots 4g.. are filled with lane indices whose bit c = 0 (at most 3).
REQ-023 Selected lanes SHALL fill slots in ascending lane order from slot 4g; unused slots SHALL be 8.
REQ-024 column_idx SHALL equal c; is_msb=1 only when c = DATA_WIDTH-1; first_col=1 only at c=0; last_col=1 only at c=DATA_WIDTH-1.
REQ-025 In this version hamming_sel SHALL be 16 (zero), hamming_sign=0, mul_const=0, is_shift_mul=0 at all times.
REQ-026 All outputs SHALL be registered; a full vector SHALL occupy exactly DATA_WIDTH+1 cycles without stall (handshake + DATA_WIDTH columns), with one IDLE cycle between vectors.
REQ-027 In IDLE, en=0, busy=0, act_sel all 8, is_skip_zero all 1, column_idx=0, is_msb/first_col/last_col=0.
REQ-028 w_valid while busy SHALL be ignored (w_ready=0); weight changes after the handshake SHALL not affect the vector in flight.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE from any state, including mid-vector and during stall, discarding the captured vector and driving the REQ-027 values; w_ready=1 on the following cycle.
REQ-030 reset SHALL take priority over w_valid and stall on the same edge.

Verification
REQ-031 All weights = 0: columns 0..7 each give is_skip_zero=2'b11, act_sel all 8; is_msb only at column 7; en high exactly 8 cycles.
REQ-032 Group 0 lanes = 8'h01 x 8, group 1 = 0: column 0 group 0 k=8 -> is_skip_zero[0]=0, slots 0..3 = 8; other columns select nothing.
REQ-033 Group 0 lanes 1,3,6 = -1 (8'hFF), rest 0: every column group 0 gives slots {1,3,6,8}, is_skip_zero[0]=1; column 7 is_msb=1.
REQ-034 stall held 3 cycles at column 4 -> column_idx=4 and act_sel held 4 cycles; vector finishes 3 cycles late; last_col at column 7.
REQ-035 reset asserted at column 5 -> next cycle en=0, w_ready=1; a new vector then restarts from column 0.
REQ-036 Back-to-back w_valid held high for two vectors -> second handshake one cycle after the first vector's column 7; no column lost or duplicated.

Source files
------------

// File: rtl/mac_ctrl_encoder_16_vert_2.sv
// Column-serial weight encoder for a 16-lane bit-serial MAC: for each bit column it
// emits per-group activation selects (the minority bit value) plus column markers.
module mac_ctrl_encoder_16_vert_2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 16,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          w_valid,
    output logic                                          w_ready,
    input  logic [DATA_WIDTH*VEC_LENGTH-1:0]              weight,
    input  logic                                          stall,
    output logic                                          en,
    output logic [(MUX_SEL_WIDTH-1)*(VEC_LENGTH/2)-1:0]   act_sel,
    output logic [VEC_LENGTH/8-1:0]                       is_skip_zero,
    output logic [2:0]                                    column_idx,
    output logic                                          is_msb,
    output logic                                          first_col,
    output logic                                          last_col,
    output logic [MUX_SEL_WIDTH-1:0]                      hamming_sel,
    output logic                                          hamming_sign,
    output logic                                          is_shift_mul,
    output logic [2:0]                                    mul_const,
    output logic                                          busy
);

    localparam int unsigned LANES   = 8;
    localparam int unsigned SLOTS   = 4;
    localparam int unsigned NGROUPS = VEC_LENGTH / 8;
    localparam int unsigned SEL_W   = MUX_SEL_WIDTH - 1;
    localparam int unsigned NSLOTS  = NGROUPS * SLOTS;
    localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(LANES);
    localparam logic [2:0]       LAST_COL = 3'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                                state_q;
    logic [2:0]                            col_q;
    logic [DATA_WIDTH*VEC_LENGTH-1:0]      w_q;
    logic [SEL_W*NSLOTS-1:0]               act_sel_q;
    logic [NGROUPS-1:0]                    skip_q;
    logic                                  en_q;
    logic                                  busy_q;
    logic                                  ready_q;
    logic                                  msb_q;
    logic                                  first_q;
    logic                                  last_q;

    logic [DATA_WIDTH*VEC_LENGTH-1:0]      src_vec;
    logic [2:0]                            enc_col;
    logic [VEC_LENGTH-1:0]                 lane_bit;
    logic [SEL_W*NSLOTS-1:0]               act_sel_d;
    logic [NGROUPS-1:0]                    skip_d;

    // Column 0 is encoded straight from the input bus on the handshake cycle so it
    // can be registered and presented on the very next cycle.
    assign src_vec = (state_q == IDLE) ? weight : w_q;
    assign enc_col = (state_q == IDLE) ? 3'd0 : col_q + 3'd1;

    for (genvar lane = 0; lane < VEC_LENGTH; lane++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_w;
        assign lane_w         = src_vec[lane*DATA_WIDTH +: DATA_WIDTH];
        assign lane_bit[lane] = lane_w[enc_col];
    end

    always_comb begin
        act_sel_d = {NSLOTS{ZERO_SEL}};
        skip_d    = '1;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            int unsigned ones;
            int unsigned fill;
            ones = 0;
            fill = 0;
            for (int unsigned l = 0; l < LANES; l++) begin
                if (lane_bit[g*LANES + l]) ones++;
            end
            skip_d[g] = (ones <= 4);
            // Select whichever bit value is in the minority; at most 4 lanes qualify.
            for (int unsigned l = 0; l < LANES; l++) begin
                if ((lane_bit[g*LANES + l] == skip_d[g]) && (fill < SLOTS)) begin
                    act_sel_d[(g*SLOTS + fill)*SEL_W +: SEL_W] = SEL_W'(l);
                    fill++;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            w_q       <= '0;
            act_sel_q <= {NSLOTS{ZERO_SEL}};
            skip_q    <= '1;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            msb_q     <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_valid) begin
                        state_q   <= EMIT;
                        w_q       <= weight;
                        col_q     <= '0;
                        act_sel_q <= act_sel_d;
                        skip_q    <= skip_d;
                        en_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                        first_q   <= 1'b1;
                        msb_q     <= (LAST_COL == 3'd0);
                        last_q    <= (LAST_COL == 3'd0);
                    end
                end
                EMIT: begin
                    if (!stall) begin
                        if (col_q == LAST_COL) begin
                            state_q   <= IDLE;
                            col_q     <= '0;
                            act_sel_q <= {NSLOTS{ZERO_SEL}};
                            skip_q    <= '1;
                            en_q      <= 1'b0;
                            busy_q    <= 1'b0;
                            ready_q   <= 1'b1;
                            msb_q     <= 1'b0;
                            first_q   <= 1'b0;
                            last_q    <= 1'b0;
                        end else begin
                            col_q     <= col_q + 3'd1;
                            act_sel_q <= act_sel_d;
                            skip_q    <= skip_d;
                            first_q   <= 1'b0;
                            msb_q     <= (col_q + 3'd1 == LAST_COL);
                            last_q    <= (col_q + 3'd1 == LAST_COL);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_ready      = ready_q;
    assign busy         = busy_q;
    assign en           = en_q;
    assign act_sel      = act_sel_q;
    assign is_skip_zero = skip_q;
    assign column_idx   = col_q;
    assign is_msb       = msb_q;
    assign first_col    = first_q;
    assign last_col     = last_q;
    assign hamming_sel  = MUX_SEL_WIDTH'(VEC_LENGTH);
    assign hamming_sign = 1'b0;
    assign is_shift_mul = 1'b0;
    assign mul_const    = 3'd0;

endmodule

// File: tb/tb_mac_ctrl_encoder_16_vert_2.sv
// Scoreboard bench: expected columns are queued at each handshake and compared
// against the DUT whenever en is high.
module tb_mac_ctrl_encoder_16_vert_2;

    typedef struct packed {
        logic [31:0] sel;
        logic [1:0]  skip;
        logic [2:0]  col;
        logic        msb;
        logic        first;
        logic        last;
    } exp_t;

    localparam exp_t IDLE_EXP = '{sel: 32'h8888_8888, skip: 2'b11, col: 3'd0,
                                  msb: 1'b0, first: 1'b0, last: 1'b0};

    logic         clk = 1'b0;
    logic         reset;
    logic         w_valid;
    logic         w_ready;
    logic [127:0] weight;
    logic         stall;
    logic         en;
    logic [31:0]  act_sel;
    logic [1:0]   is_skip_zero;
    logic [2:0]   column_idx;
    logic         is_msb, first_col, last_col;
    logic [4:0]   hamming_sel;
    logic         hamming_sign, is_shift_mul;
    logic [2:0]   mul_const;
    logic         busy;

    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    bit   mon_on  = 1'b0;
    exp_t sb[$];

    mac_ctrl_encoder_16_vert_2 #(
        .DATA_WIDTH(8),
        .VEC_LENGTH(16)
    ) dut (
        .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready),
        .weight(weight), .stall(stall), .en(en), .act_sel(act_sel),
        .is_skip_zero(is_skip_zero), .column_idx(column_idx), .is_msb(is_msb),
        .first_col(first_col), .last_col(last_col), .hamming_sel(hamming_sel),
        .hamming_sign(hamming_sign), .is_shift_mul(is_shift_mul),
        .mul_const(mul_const), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: pick the minority bit value per group, list lanes lowest first.
    function automatic exp_t model(input logic [127:0] v, input int c);
        exp_t e;
        e.sel = '0;
        for (int s = 0; s < 8; s++) e.sel[s*4 +: 4] = 4'd8;
        for (int g = 0; g < 2; g++) begin
            logic [7:0] b, m;
            int n;
            for (int l = 0; l < 8; l++) b[l] = v[(g*8 + l)*8 + c];
            e.skip[g] = ($countones(b) <= 4);
            m = e.skip[g] ? b : ~b;
            n = 0;
            while (m != 8'd0 && n < 4) begin
                int low;
                low = 0;
                while (!m[low]) low++;
                e.sel[(g*4 + n)*4 +: 4] = 4'(low);
                m[low] = 1'b0;
                n++;
            end
        end
        e.col   = 3'(c);
        e.msb   = (c == 7);
        e.first = (c == 0);
        e.last  = (c == 7);
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = '{sel: act_sel, skip: is_skip_zero, col: column_idx,
              msb: is_msb, first: first_col, last: last_col};
        return o;
    endfunction

    always @(negedge clk) begin
        if (mon_on && !reset) begin
            chk("ready_vs_busy", 64'(w_ready), 64'(!busy));
            if (en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_column", 64'(en), 64'(0));
                end else begin
                    chk("column", 64'(observed()), 64'(sb[0]));
                    chk("special_ctrl", 64'({hamming_sel, hamming_sign, is_shift_mul, mul_const}),
                        64'({5'd16, 1'b0, 1'b0, 3'd0}));
                    if (!stall) void'(sb.pop_front());
                end
            end else begin
                chk("idle_outputs", 64'({observed(), busy}), 64'({IDLE_EXP, 1'b0}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [127:0] v);
        for (int c = 0; c < 8; c++) sb.push_back(model(v, c));
    endtask

    function automatic logic [127:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic handshake(input logic [127:0] v);
        w_valid = 1'b1;
        weight  = v;
        for (int i = 0; i < 50 && !w_ready; i++) tick();
        chk("handshake_ready", 64'(w_ready), 64'(1));
        push_vec(v);
        tick();
        w_valid = 1'b0;
        weight  = rnd_vec();
    endtask

    task automatic run_vec(input logic [127:0] v, input int stall_col, input int stall_len);
        int cnt;
        int left;
        cnt  = 0;
        left = stall_len;
        handshake(v);
        for (int i = 0; i < 60 && en; i++) begin
            cnt++;
            if (int'(column_idx) == stall_col && left > 0) begin
                stall = 1'b1;
                left--;
            end else begin
                stall = 1'b0;
            end
            tick();
        end
        stall = 1'b0;
        chk("en_cycles", 64'(cnt), 64'(8 + stall_len));
        chk("ready_after_vec", 64'(w_ready), 64'(1));
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic [127:0] v;
        int gap;
        reset   = 1'b1;
        w_valid = 1'b0;
        stall   = 1'b0;
        weight  = '0;
        repeat (3) tick();
        reset  = 1'b0;
        mon_on = 1'b1;
        chk("reset_ready", 64'(w_ready), 64'(1));
        chk("reset_en", 64'(en), 64'(0));
        chk("reset_outputs", 64'(observed()), 64'(IDLE_EXP));

        // All-zero weights
        run_vec(128'd0, -1, 0);

        // Group 0 lanes = 1, group 1 = 0
        run_vec({64'd0, {8{8'h01}}}, -1, 0);

        // Group 0 lanes 1,3,6 = -1
        v = '0;
        v[1*8 +: 8] = 8'hFF;
        v[3*8 +: 8] = 8'hFF;
        v[6*8 +: 8] = 8'hFF;
        run_vec(v, -1, 0);

        // Dense and sparse random vectors hit both skip polarities
        run_vec(rnd_vec() | rnd_vec() | rnd_vec(), -1, 0);
        run_vec(rnd_vec() & rnd_vec(), -1, 0);
        run_vec(rnd_vec(), -1, 0);

        // Stall 3 cycles at column 4
        run_vec(rnd_vec(), 4, 3);

        // Reset at column 5, together with stall and w_valid
        handshake(rnd_vec());
        for (int i = 0; i < 20 && !(en && column_idx == 3'd5); i++) tick();
        chk("reached_col5", 64'(column_idx), 64'(5));
        reset   = 1'b1;
        stall   = 1'b1;
        w_valid = 1'b1;
        sb.delete();
        tick();
        reset   = 1'b0;
        stall   = 1'b0;
        w_valid = 1'b0;
        chk("rst_mid_en", 64'(en), 64'(0));
        chk("rst_mid_ready", 64'(w_ready), 64'(1));
        chk("rst_mid_col", 64'(column_idx), 64'(0));
        tick();
        run_vec(rnd_vec(), -1, 0);

        // Back-to-back with w_valid held high
        v = rnd_vec();
        w_valid = 1'b1;
        weight  = v;
        for (int i = 0; i < 50 && !w_ready; i++) tick();
        push_vec(v);
        tick();
        v      = rnd_vec();
        weight = v;
        gap    = 0;
        for (int i = 0; i < 30 && !w_ready; i++) begin
            gap++;
            tick();
        end
        chk("b2b_gap", 64'(gap), 64'(8));
        push_vec(v);
        tick();
        w_valid = 1'b0;
        for (int i = 0; i < 40 && (en || sb.size() != 0); i++) tick();
        chk("b2b_drained", 64'(sb.size()), 64'(0));
        chk("b2b_ready", 64'(w_ready), 64'(1));

        tick();
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
